// File: rtl/pwm_capture.sv
// Four-channel PWM period/high-time capture unit with a register-mapped bus.
// Each channel synchronizes its pin and measures its period and high time in clk cycles.

module pwm_capture_ch (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pin,
    output logic [31:0] period,
    output logic [31:0] high,
    output logic        cap,
    output logic        ovf
);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic        sync1_r;
    logic        sync2_r;
    logic        prev_r;
    logic        armed_r;
    logic        rise_s;
    logic [31:0] cnt_r;
    logic [31:0] hcnt_r;
    logic [31:0] hcnt_inc_s;

    // Two-flop synchronizer plus a history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Edge, capture and overflow qualifiers; capture/overflow feed the shared status register
    always_comb begin
        rise_s     = sync2_r & ~prev_r;
        cap        = en & rise_s & armed_r;
        ovf        = en & ~rise_s & (cnt_r == CNT_MAX);
        hcnt_inc_s = hcnt_r;
        if (sync2_r && (hcnt_r != CNT_MAX)) begin
            hcnt_inc_s = hcnt_r + 32'd1;
        end else begin
            hcnt_inc_s = hcnt_r;
        end
    end

    // Period/high counters, arming and capture of the finished measurement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= 32'd0;
            hcnt_r  <= 32'd0;
            armed_r <= 1'b0;
            period  <= 32'd0;
            high    <= 32'd0;
        end else if (!en) begin
            cnt_r   <= 32'd0;
            hcnt_r  <= 32'd0;
            armed_r <= 1'b0;
        end else if (rise_s) begin
            if (armed_r) begin
                period <= cnt_r;
                high   <= hcnt_r;
            end
            armed_r <= 1'b1;
            cnt_r   <= 32'd1;
            hcnt_r  <= 32'd1;
        end else if (cnt_r == CNT_MAX) begin
            // The period is no longer measurable; the next edge must re-arm.
            armed_r <= 1'b0;
            hcnt_r  <= hcnt_inc_s;
        end else begin
            cnt_r  <= cnt_r + 32'd1;
            hcnt_r <= hcnt_inc_s;
        end
    end
endmodule

module pwm_capture #(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        cap_pin0,
    input  logic        cap_pin1,
    input  logic        cap_pin2,
    input  logic        cap_pin3
);
    logic [NCH-1:0]        pin_s;
    logic [NCH-1:0][31:0]  period_s;
    logic [NCH-1:0][31:0]  high_s;
    logic [NCH-1:0]        cap_s;
    logic [NCH-1:0]        ovf_s;
    logic [NCH-1:0]        en_r;
    logic [NCH-1:0]        valid_r;
    logic [NCH-1:0]        ovf_r;
    logic [7:0]            sel_s;
    logic                  wr_ctrl_s;
    logic                  wr_stat_s;
    logic [NCH-1:0]        clr_valid_s;
    logic [NCH-1:0]        clr_ovf_s;
    logic                  unused_s;

    assign pin_s    = {cap_pin3, cap_pin2, cap_pin1, cap_pin0};
    assign unused_s = ^{addr_i[31:24], addr_i[15:0], data_i[31:12], data_i[7:4]};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_capture_ch u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en_r[g]),
            .pin    (pin_s[g]),
            .period (period_s[g]),
            .high   (high_s[g]),
            .cap    (cap_s[g]),
            .ovf    (ovf_s[g])
        );
    end

    // Bus write decode
    always_comb begin
        sel_s       = addr_i[23:16];
        wr_ctrl_s   = we_i && (sel_s == 8'h04);
        wr_stat_s   = we_i && (sel_s == 8'h05);
        clr_valid_s = {NCH{1'b0}};
        clr_ovf_s   = {NCH{1'b0}};
        if (wr_stat_s) begin
            clr_valid_s = data_i[3:0];
            clr_ovf_s   = data_i[11:8];
        end else begin
            clr_valid_s = {NCH{1'b0}};
            clr_ovf_s   = {NCH{1'b0}};
        end
    end

    // Control and status registers; a hardware set in the same cycle beats write-1-to-clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r    <= {NCH{1'b0}};
            valid_r <= {NCH{1'b0}};
            ovf_r   <= {NCH{1'b0}};
        end else begin
            if (wr_ctrl_s) begin
                en_r <= data_i[3:0];
            end
            valid_r <= (valid_r & ~clr_valid_s) | cap_s;
            ovf_r   <= (ovf_r & ~clr_ovf_s) | ovf_s;
        end
    end

    // Combinational read mux, forced to zero while in reset
    always_comb begin
        data_o = 32'h0000_0000;
        if (rst) begin
            case (sel_s)
                8'h00, 8'h01, 8'h02, 8'h03: data_o = period_s[sel_s[1:0]];
                8'h10, 8'h11, 8'h12, 8'h13: data_o = high_s[sel_s[1:0]];
                8'h04:                      data_o = {28'h000_0000, en_r};
                8'h05:                      data_o = {20'h0_0000, ovf_r, 4'h0, valid_r};
                default:                    data_o = 32'h0000_0000;
            endcase
        end else begin
            data_o = 32'h0000_0000;
        end
    end
endmodule
